ddr_frame_arbiter: RTL and testbench
====================================

Name: ddr_frame_arbiter

Overview:
- Sits directly upstream of the DDR2 burst wrapper.
- Turns the camera write FIFO and the VGA read FIFO into burst read and burst write requests with lengths and addresses.
- Holds two frame buffers in DDR (ping-pong). Camera frames are written into one while VGA frames are read from the last completed one.
- Passes the wrapper's data strobes through as FIFO read and write enables.

Parameters:
- ADDR_BITS, 25, width of burst addresses and word counters.
- BURST_LEN, 10'd128, maximum words per burst request; must be in 1..1023.
- FRAME_WORDS, 25'd153600, words per frame (640x480x16b / 32b).
- BUF0_BASE, 25'h0000000, base word address of buffer 0.
- BUF1_BASE, 25'h0040000, base word address of buffer 1.
- RD_LOW_WM, 11'd256, a read burst is requested while VGA FIFO level is below this.
- FIFO_LVL_BITS, 11, width of FIFO level inputs.

Ports:
- mem_clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- local_init_done  in  1  DDR calibrated; no request issues while low.
- wr_frame_start  in  1  one-cycle pulse in mem_clk domain, start of camera frame.
- rd_frame_start  in  1  one-cycle pulse in mem_clk domain, start of VGA frame.
- wr_fifo_usedw  in  FIFO_LVL_BITS  words available in camera FIFO.
- rd_fifo_usedw  in  FIFO_LVL_BITS  words held in VGA FIFO.
- wr_burst_req  out  1  burst write request to wrapper.
- wr_burst_len  out  10  write burst length.
- wr_burst_addr  out  ADDR_BITS  write burst start address.
- wr_burst_finish  in  1  wrapper write done.
- wr_burst_data_req  in  1  wrapper wants next write word.
- wr_fifo_rdreq  out  1  = wr_burst_data_req (combinational).
- rd_burst_req  out  1  burst read request to wrapper.
- rd_burst_len  out  10  read burst length.
- rd_burst_addr  out  ADDR_BITS  read burst start address.
- rd_burst_finish  in  1  wrapper read done.
- rd_burst_data_valid  in  1  wrapper read word valid.
- rd_fifo_wrreq  out  1  = rd_burst_data_valid gated by rd_active (combinational).

Behaviour:
- Reset values: all outputs except the two pass-throughs = 0; state IDLE; wr_buf=0; rd_buf=1; frame_valid=0; counters 0; pending flags 0.
- FSM states: IDLE, WR_BURST, RD_BURST. In IDLE with local_init_done low, the FSM stays in IDLE.
- Read condition (rd_need): frame_valid & rd_active & (rd_cnt < FRAME_WORDS) & (rd_fifo_usedw < RD_LOW_WM).
- Write condition (wr_need): wr_active & (wr_cnt < FRAME_WORDS) & (wr_fifo_usedw >= wr_len_next).
- Length rule: wr_len_next / rd_len_next = min(BURST_LEN, FRAME_WORDS - cnt), truncated to 10 bits.
- IDLE priority: rd_need beats wr_need (fixed priority unless the optional feature is enabled).
  - On selection, register req=1, len, and addr = base(buf) + cnt; move to RD_BURST or WR_BURST.
  - Request is asserted the cycle after the decision.
- In RD_BURST/WR_BURST: req, len and addr are held stable until the matching *_finish.
  - On the finish cycle: req<=0; cnt += len; next state IDLE.
  - The request is therefore low when the wrapper re-enters IDLE, so there is no double issue.
  - The finish of the other direction is ignored.
- wr_frame_start handling:
  - Sets wr_start_pend.
  - Applied only in IDLE (a burst in flight always completes). A second pulse before it is applied is absorbed.
  - On apply, if the previous write frame completed (wr_cnt == FRAME_WORDS): rd_buf_next <= wr_buf; wr_buf toggles; frame_valid <= 1.
  - On apply, if the previous frame was incomplete: the same buffer is rewritten and no swap occurs.
  - In both cases wr_cnt <= 0 and wr_active <= 1.
- rd_frame_start handling:
  - Sets rd_start_pend; applied in IDLE.
  - rd_buf <= rd_buf_next, latched per frame so a read frame never tears; rd_cnt <= 0; rd_active <= 1.
- rd_fifo_wrreq is only asserted while state == RD_BURST.
- Frame end: cnt reaching FRAME_WORDS stops requests until the next frame-start pulse.
- Simultaneous frame-start pulses in the same cycle: both are applied in the same IDLE cycle. The write swap is evaluated first, so the read side gets the just-completed buffer.
- Address arithmetic is modulo 2^ADDR_BITS; a base + FRAME_WORDS overflow wraps silently, and the integrator is responsible for keeping it out of range.
- local_init_done falling mid-burst: the FSM returns to IDLE, req=0, and counters are kept. The interrupted burst is reissued from the unchanged cnt (cnt is only advanced on finish).

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: a last_grant register (reset 0 = write).
  - When both needs are true in IDLE, the direction not granted last wins.
  - rd_need alone still wins immediately.
- Undefined: fixed read-over-write priority as above, and no last_grant register.

Test Plan:
- Common setup: BURST_LEN=8, FRAME_WORDS=20, BUF0_BASE=0, BUF1_BASE=100, RD_LOW_WM=16, plus a wrapper model finishing 12 cycles after req.
- Write frame: pulse wr_frame_start, hold wr_fifo_usedw=20 -> three write bursts: (addr 0, len 8), (addr 8, len 8), (addr 16, len 4); then no further wr_burst_req.
- Buffer swap: complete the write frame, pulse wr_frame_start, then rd_frame_start, rd_fifo_usedw=0 -> write bursts target addr 100.., read bursts target addr 0, 8, 16 with lengths 8, 8, 4.
- Incomplete frame: pulse wr_frame_start after only 8 words written -> no swap, the next write burst is at addr 0, and frame_valid is unchanged.
- Contention: rd_need and wr_need both true in IDLE -> read granted.
  - ARB_ROUND_ROBIN_EN defined: grants alternate R,W,R,W.
  - Not defined: R,R,R then W.
- Handshake: at every *_finish cycle, the req is 0 on the next cycle; len and addr do not change while req=1; rd_fifo_wrreq stays 0 for rd_burst_data_valid pulses outside RD_BURST.
- Reset and init: assert rst_n low mid-burst -> all outputs 0 asynchronously. Drop local_init_done mid-write -> req drops; when it is restored, the same addr and len are reissued.

Source files
------------

// File: rtl/ddr_frame_arbiter.sv
// Ping-pong frame-buffer arbiter turning camera/VGA FIFO levels into DDR2 burst requests.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants when read and write contend.
module ddr_frame_arbiter #(
    parameter int unsigned          ADDR_BITS     = 25,
    parameter int unsigned          FIFO_LVL_BITS = 11,
    parameter logic [9:0]           BURST_LEN     = 10'd128,
    parameter logic [ADDR_BITS-1:0] FRAME_WORDS   = 25'd153600,
    parameter logic [ADDR_BITS-1:0] BUF0_BASE     = 25'h0000000,
    parameter logic [ADDR_BITS-1:0] BUF1_BASE     = 25'h0040000,
    parameter logic [FIFO_LVL_BITS-1:0] RD_LOW_WM = 11'd256
) (
    input  logic                     mem_clk,
    input  logic                     rst_n,
    input  logic                     local_init_done,
    input  logic                     wr_frame_start,
    input  logic                     rd_frame_start,
    input  logic [FIFO_LVL_BITS-1:0] wr_fifo_usedw,
    input  logic [FIFO_LVL_BITS-1:0] rd_fifo_usedw,
    output logic                     wr_burst_req,
    output logic [9:0]               wr_burst_len,
    output logic [ADDR_BITS-1:0]     wr_burst_addr,
    input  logic                     wr_burst_finish,
    input  logic                     wr_burst_data_req,
    output logic                     wr_fifo_rdreq,
    output logic                     rd_burst_req,
    output logic [9:0]               rd_burst_len,
    output logic [ADDR_BITS-1:0]     rd_burst_addr,
    input  logic                     rd_burst_finish,
    input  logic                     rd_burst_data_valid,
    output logic                     rd_fifo_wrreq
);
    localparam int unsigned LEN_BITS = 10;
    localparam int unsigned CMP_BITS = (FIFO_LVL_BITS > LEN_BITS) ? FIFO_LVL_BITS : LEN_BITS;

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

    state_t                 state, state_nxt;
    logic                   wr_buf, wr_buf_nxt, rd_buf, rd_buf_nxt, rd_buf_pend, rd_buf_pend_nxt;
    logic                   frame_valid, frame_valid_nxt;
    logic                   wr_active, wr_active_nxt, rd_active, rd_active_nxt;
    logic                   wr_start_pend, wr_start_pend_nxt, rd_start_pend, rd_start_pend_nxt;
    logic [ADDR_BITS-1:0]   wr_cnt, wr_cnt_nxt, rd_cnt, rd_cnt_nxt;
    logic                   wr_req_nxt, rd_req_nxt;
    logic [LEN_BITS-1:0]    wr_len_nxt, rd_len_nxt, wr_len_next, rd_len_next;
    logic [ADDR_BITS-1:0]   wr_addr_nxt, rd_addr_nxt, wr_remain, rd_remain;
    logic                   wr_start, rd_start, wr_need, rd_need, grant_rd;
`ifdef ARB_ROUND_ROBIN_EN
    logic                   last_grant, last_grant_nxt;
`endif

    assign wr_fifo_rdreq = wr_burst_data_req;
    assign rd_fifo_wrreq = rd_burst_data_valid && rd_active && (state == RD_BURST);

    // Burst sizing and request conditions
    always_comb begin
        wr_remain   = FRAME_WORDS - wr_cnt;
        rd_remain   = FRAME_WORDS - rd_cnt;
        wr_len_next = (wr_remain < ADDR_BITS'(BURST_LEN)) ? LEN_BITS'(wr_remain) : BURST_LEN;
        rd_len_next = (rd_remain < ADDR_BITS'(BURST_LEN)) ? LEN_BITS'(rd_remain) : BURST_LEN;
        wr_need     = wr_active && (wr_cnt < FRAME_WORDS)
                      && (CMP_BITS'(wr_fifo_usedw) >= CMP_BITS'(wr_len_next));
        rd_need     = frame_valid && rd_active && (rd_cnt < FRAME_WORDS)
                      && (rd_fifo_usedw < RD_LOW_WM);
`ifdef ARB_ROUND_ROBIN_EN
        grant_rd    = rd_need && (!wr_need || !last_grant);
`else
        grant_rd    = rd_need;
`endif
        wr_start    = wr_start_pend || wr_frame_start;
        rd_start    = rd_start_pend || rd_frame_start;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nxt         = state;
        wr_buf_nxt        = wr_buf;
        rd_buf_nxt        = rd_buf;
        rd_buf_pend_nxt   = rd_buf_pend;
        frame_valid_nxt   = frame_valid;
        wr_active_nxt     = wr_active;
        rd_active_nxt     = rd_active;
        wr_start_pend_nxt = wr_start;
        rd_start_pend_nxt = rd_start;
        wr_cnt_nxt        = wr_cnt;
        rd_cnt_nxt        = rd_cnt;
        wr_req_nxt        = wr_burst_req;
        wr_len_nxt        = wr_burst_len;
        wr_addr_nxt       = wr_burst_addr;
        rd_req_nxt        = rd_burst_req;
        rd_len_nxt        = rd_burst_len;
        rd_addr_nxt       = rd_burst_addr;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_nxt    = last_grant;
`endif
        unique case (state)
            IDLE: begin
                if (wr_start || rd_start) begin
                    // Write swap resolves first so a same-cycle read start picks up the fresh frame
                    if (wr_start) begin
                        wr_start_pend_nxt = 1'b0;
                        if (wr_cnt == FRAME_WORDS) begin
                            rd_buf_pend_nxt = wr_buf;
                            wr_buf_nxt      = ~wr_buf;
                            frame_valid_nxt = 1'b1;
                        end
                        wr_cnt_nxt    = '0;
                        wr_active_nxt = 1'b1;
                    end
                    if (rd_start) begin
                        rd_start_pend_nxt = 1'b0;
                        rd_buf_nxt        = rd_buf_pend_nxt;
                        rd_cnt_nxt        = '0;
                        rd_active_nxt     = 1'b1;
                    end
                end else if (local_init_done) begin
                    if (grant_rd) begin
                        rd_req_nxt  = 1'b1;
                        rd_len_nxt  = rd_len_next;
                        rd_addr_nxt = (rd_buf ? BUF1_BASE : BUF0_BASE) + rd_cnt;
                        state_nxt   = RD_BURST;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_nxt = 1'b1;
`endif
                    end else if (wr_need) begin
                        wr_req_nxt  = 1'b1;
                        wr_len_nxt  = wr_len_next;
                        wr_addr_nxt = (wr_buf ? BUF1_BASE : BUF0_BASE) + wr_cnt;
                        state_nxt   = WR_BURST;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_nxt = 1'b0;
`endif
                    end
                end
            end
            WR_BURST: begin
                if (wr_burst_finish) begin
                    wr_req_nxt = 1'b0;
                    wr_cnt_nxt = wr_cnt + ADDR_BITS'(wr_burst_len);
                    state_nxt  = IDLE;
                end else if (!local_init_done) begin
                    wr_req_nxt = 1'b0;
                    state_nxt  = IDLE;
                end
            end
            RD_BURST: begin
                if (rd_burst_finish) begin
                    rd_req_nxt = 1'b0;
                    rd_cnt_nxt = rd_cnt + ADDR_BITS'(rd_burst_len);
                    state_nxt  = IDLE;
                end else if (!local_init_done) begin
                    rd_req_nxt = 1'b0;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_buf        <= 1'b0;
            rd_buf        <= 1'b1;
            rd_buf_pend   <= 1'b1;
            frame_valid   <= 1'b0;
            wr_active     <= 1'b0;
            rd_active     <= 1'b0;
            wr_start_pend <= 1'b0;
            rd_start_pend <= 1'b0;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            wr_burst_req  <= 1'b0;
            wr_burst_len  <= '0;
            wr_burst_addr <= '0;
            rd_burst_req  <= 1'b0;
            rd_burst_len  <= '0;
            rd_burst_addr <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant    <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            wr_buf        <= wr_buf_nxt;
            rd_buf        <= rd_buf_nxt;
            rd_buf_pend   <= rd_buf_pend_nxt;
            frame_valid   <= frame_valid_nxt;
            wr_active     <= wr_active_nxt;
            rd_active     <= rd_active_nxt;
            wr_start_pend <= wr_start_pend_nxt;
            rd_start_pend <= rd_start_pend_nxt;
            wr_cnt        <= wr_cnt_nxt;
            rd_cnt        <= rd_cnt_nxt;
            wr_burst_req  <= wr_req_nxt;
            wr_burst_len  <= wr_len_nxt;
            wr_burst_addr <= wr_addr_nxt;
            rd_burst_req  <= rd_req_nxt;
            rd_burst_len  <= rd_len_nxt;
            rd_burst_addr <= rd_addr_nxt;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant    <= last_grant_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_ddr_frame_arbiter.sv
// Directed bench for ddr_frame_arbiter with a small frame (20 words, 8-word bursts).
module tb_ddr_frame_arbiter;
    localparam int unsigned AW = 25;
    localparam int unsigned LW = 11;

    logic          mem_clk = 1'b0;
    logic          rst_n;
    logic          local_init_done;
    logic          wr_frame_start, rd_frame_start;
    logic [LW-1:0] wr_fifo_usedw, rd_fifo_usedw;
    logic          wr_burst_req, rd_burst_req;
    logic [9:0]    wr_burst_len, rd_burst_len;
    logic [AW-1:0] wr_burst_addr, rd_burst_addr;
    logic          wr_burst_finish, wr_burst_data_req, wr_fifo_rdreq;
    logic          rd_burst_finish, rd_burst_data_valid, rd_fifo_wrreq;

    int checks = 0;
    int errors = 0;

    always #5 mem_clk = ~mem_clk;

    ddr_frame_arbiter #(
        .ADDR_BITS(AW), .FIFO_LVL_BITS(LW), .BURST_LEN(10'd8), .FRAME_WORDS(25'd20),
        .BUF0_BASE(25'd0), .BUF1_BASE(25'd100), .RD_LOW_WM(11'd16)
    ) dut (
        .mem_clk(mem_clk), .rst_n(rst_n), .local_init_done(local_init_done),
        .wr_frame_start(wr_frame_start), .rd_frame_start(rd_frame_start),
        .wr_fifo_usedw(wr_fifo_usedw), .rd_fifo_usedw(rd_fifo_usedw),
        .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
        .wr_burst_finish(wr_burst_finish), .wr_burst_data_req(wr_burst_data_req),
        .wr_fifo_rdreq(wr_fifo_rdreq),
        .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
        .rd_burst_finish(rd_burst_finish), .rd_burst_data_valid(rd_burst_data_valid),
        .rd_fifo_wrreq(rd_fifo_wrreq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input int bound);
        int n = 0;
        while (!(wr_burst_req || rd_burst_req) && n < bound) begin
            @(negedge mem_clk);
            n++;
        end
    endtask

    task automatic expect_idle(input string tag, input int n);
        logic any = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge mem_clk);
            any |= wr_burst_req | rd_burst_req;
        end
        check(tag, 32'(any), 32'd0);
    endtask

    // Wrapper model: accept the next request, hold it 12 cycles, then finish
    task automatic do_burst(input string tag, input logic is_rd,
                            input logic [AW-1:0] exp_addr, input logic [9:0] exp_len);
        logic [AW-1:0] a0;
        logic [9:0]    l0;
        logic          stable = 1'b1;
        wait_req(60);
        check({tag, " req"}, 32'(wr_burst_req | rd_burst_req), 32'd1);
        check({tag, " dir"}, 32'(rd_burst_req), 32'(is_rd));
        a0 = is_rd ? rd_burst_addr : wr_burst_addr;
        l0 = is_rd ? rd_burst_len : wr_burst_len;
        check({tag, " addr"}, 32'(a0), 32'(exp_addr));
        check({tag, " len"}, 32'(l0), 32'(exp_len));
        for (int i = 0; i < 12; i++) begin
            if (i == 3) begin
                if (is_rd) wr_burst_finish = 1'b1;
                else       rd_burst_finish = 1'b1;
            end
            if (i == 4) begin
                wr_burst_finish = 1'b0;
                rd_burst_finish = 1'b0;
            end
            if (i == 5) begin
                rd_burst_data_valid = 1'b1;
                wr_burst_data_req   = 1'b1;
                #1;
                check({tag, " rd_fifo_wrreq"}, 32'(rd_fifo_wrreq), 32'(is_rd));
                check({tag, " wr_fifo_rdreq"}, 32'(wr_fifo_rdreq), 32'd1);
                rd_burst_data_valid = 1'b0;
                wr_burst_data_req   = 1'b0;
            end
            @(negedge mem_clk);
            if (is_rd) stable &= rd_burst_req && (rd_burst_addr == a0) && (rd_burst_len == l0);
            else       stable &= wr_burst_req && (wr_burst_addr == a0) && (wr_burst_len == l0);
        end
        check({tag, " stable"}, 32'(stable), 32'd1);
        if (is_rd) rd_burst_finish = 1'b1;
        else       wr_burst_finish = 1'b1;
        @(negedge mem_clk);
        rd_burst_finish = 1'b0;
        wr_burst_finish = 1'b0;
        check({tag, " req drop"}, 32'(wr_burst_req | rd_burst_req), 32'd0);
    endtask

    logic          seq_rd   [6];
    logic [AW-1:0] seq_addr [6];
    logic [9:0]    seq_len  [6];

    initial begin
        rst_n = 1'b0; local_init_done = 1'b1;
        wr_frame_start = 1'b0; rd_frame_start = 1'b0;
        wr_fifo_usedw = '0; rd_fifo_usedw = '0;
        wr_burst_finish = 1'b0; wr_burst_data_req = 1'b0;
        rd_burst_finish = 1'b0; rd_burst_data_valid = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        seq_rd = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        seq_addr = '{25'd0, 25'd100, 25'd8, 25'd108, 25'd16, 25'd116};
        seq_len  = '{10'd8, 10'd8, 10'd8, 10'd8, 10'd4, 10'd4};
`else
        seq_rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        seq_addr = '{25'd0, 25'd8, 25'd16, 25'd100, 25'd108, 25'd116};
        seq_len  = '{10'd8, 10'd8, 10'd4, 10'd8, 10'd8, 10'd4};
`endif
        repeat (2) @(negedge mem_clk);
        check("reset wr_req", 32'(wr_burst_req), 32'd0);
        check("reset rd_req", 32'(rd_burst_req), 32'd0);
        check("reset wr_len/addr", 32'(wr_burst_len) | 32'(wr_burst_addr), 32'd0);
        check("reset rd_len/addr", 32'(rd_burst_len) | 32'(rd_burst_addr), 32'd0);
        rst_n = 1'b1;
        @(negedge mem_clk);

        // First write frame into buffer 0
        wr_fifo_usedw = 11'd20;
        wr_frame_start = 1'b1;
        @(negedge mem_clk);
        wr_frame_start = 1'b0;
        check("req one cycle after decision", 32'(wr_burst_req), 32'd0);
        do_burst("wr0", 1'b0, 25'd0, 10'd8);
        do_burst("wr1", 1'b0, 25'd8, 10'd8);
        do_burst("wr2", 1'b0, 25'd16, 10'd4);
        expect_idle("frame end no req", 10);
        rd_burst_data_valid = 1'b1;
        #1;
        check("idle rd_fifo_wrreq", 32'(rd_fifo_wrreq), 32'd0);
        rd_burst_data_valid = 1'b0;

        // Simultaneous starts: swap, then read/write contention
        @(negedge mem_clk);
        wr_frame_start = 1'b1;
        rd_frame_start = 1'b1;
        @(negedge mem_clk);
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
        for (int i = 0; i < 6; i++)
            do_burst($sformatf("contend%0d", i), seq_rd[i], seq_addr[i], seq_len[i]);
        expect_idle("both frames done", 8);

        // Complete frame swap, then an incomplete frame that must not swap
        wr_frame_start = 1'b1;
        @(negedge mem_clk);
        wr_frame_start = 1'b0;
        do_burst("swap back wr", 1'b0, 25'd0, 10'd8);
        wr_fifo_usedw = 11'd0;
        expect_idle("partial frame stalls", 5);
        wr_fifo_usedw = 11'd20;
        wr_frame_start = 1'b1;
        @(negedge mem_clk);
        wr_frame_start = 1'b0;
        do_burst("no swap wr", 1'b0, 25'd0, 10'd8);
        wr_fifo_usedw = 11'd0;
        rd_frame_start = 1'b1;
        @(negedge mem_clk);
        rd_frame_start = 1'b0;
        do_burst("rd buf1", 1'b1, 25'd100, 10'd8);
        rd_fifo_usedw = 11'd16;
        expect_idle("rd at watermark", 5);
        rd_fifo_usedw = 11'd15;
        do_burst("rd below wm", 1'b1, 25'd108, 10'd8);
        rd_fifo_usedw = 11'd16;

        // Write level just below burst length, then init drop mid-burst
        wr_fifo_usedw = 11'd7;
        expect_idle("wr level below len", 5);
        wr_fifo_usedw = 11'd8;
        wait_req(20);
        check("pre-drop addr", 32'(wr_burst_addr), 32'd8);
        local_init_done = 1'b0;
        @(negedge mem_clk);
        check("init drop req", 32'(wr_burst_req), 32'd0);
        expect_idle("init low idle", 4);
        local_init_done = 1'b1;
        do_burst("reissue", 1'b0, 25'd8, 10'd8);

        // Asynchronous reset during a live request
        wait_req(20);
        check("pre-reset req", 32'(wr_burst_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset req", 32'(wr_burst_req | rd_burst_req), 32'd0);
        check("async reset wr_len/addr", 32'(wr_burst_len) | 32'(wr_burst_addr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
